// File: rtl/cam_crop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_crop_pkg                                                          |
// | Shared encodings for the cropping camera decoder.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cam_crop_pkg;

    localparam logic [1:0] ORD_UYVY = 2'd0;
    localparam logic [1:0] ORD_VYUY = 2'd1;
    localparam logic [1:0] ORD_YUYV = 2'd2;
    localparam logic [1:0] ORD_YVYU = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Slot index of byte k within a group: 0=U, 1=Y0, 2=V, 3=Y1.
    function automatic logic [1:0] slot_of(input logic [1:0] order, input logic [1:0] k);
        logic [1:0] s;
        case (order)
            ORD_UYVY: s = k;
            ORD_VYUY: s = k[0] ? k : (k ^ 2'd2);
            ORD_YUYV: s = k ^ 2'd1;
            ORD_YVYU: s = k + 2'd1;
            default:  s = k;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_byte_sorter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_byte_sorter                                                       |
// | Groups 4:2:2 bytes into canonical {U,Y0,V,Y1} words with a strobe.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cam_byte_sorter
    import cam_crop_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_href,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [1:0]          i_order,
    output logic [4*DATA_W-1:0] o_word,
    output logic                o_word_valid,
    output logic [1:0]          o_byte_cnt
);

    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        order_q, order_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] slot_q [4];
    logic [DATA_W-1:0] slot_d [4];

    always_comb begin
        cnt_d   = i_href ? cnt_q + 2'd1 : 2'd0;
        // Byte order only changes between lines so a group is never split across orders.
        order_d = i_href ? order_q : i_order;
        valid_d = i_href && (cnt_q == 2'd3);
        slot_d  = slot_q;
        if (i_href) begin
            slot_d[slot_of(order_q, cnt_q)] = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            order_q <= ORD_UYVY;
            valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            order_q <= order_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign o_word       = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
    assign o_word_valid = valid_q;
    assign o_byte_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cam_crop_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_crop_decoder                                                      |
// | 4:2:2 camera decoder with crop window, frame arming and line checks.  |
// | Optional luma accumulator: CAM_CROP_DECODER_LUMA_SUM_EN.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cam_crop_decoder
    import cam_crop_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 12,
    parameter int FCNT_W  = 16
) (
    input  logic                PCLK,
    input  logic                PRST,
    input  logic                CAPON,
    input  logic                HREF,
    input  logic                VSYNC,
    input  logic [DATA_W-1:0]   CAMDATA,
    input  logic [1:0]          ORDER,
    input  logic [COORD_W-1:0]  FRAME_W,
    input  logic [COORD_W-1:0]  FRAME_H,
    input  logic [COORD_W-1:0]  CROP_X0,
    input  logic [COORD_W-1:0]  CROP_Y0,
    input  logic [COORD_W-1:0]  CROP_W,
    input  logic [COORD_W-1:0]  CROP_H,
    output logic [4*DATA_W-1:0] FIFOIN,
    output logic                FIFOWR,
    output logic                FIFORST,
    output logic                FOUND_HREF,
    output logic                FRAME_DONE,
    output logic                LINE_ERR,
    output logic [FCNT_W-1:0]   FRAME_CNT,
    output logic [31:0]         LUMA_SUM
);

    logic [4*DATA_W-1:0] w_word;
    logic                w_word_valid;
    logic [1:0]          w_byte_cnt;

    cam_byte_sorter #(.DATA_W(DATA_W)) u_sorter (
        .clk          (PCLK),
        .rst          (PRST),
        .i_href       (HREF),
        .i_data       (CAMDATA),
        .i_order      (ORDER),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_byte_cnt   (w_byte_cnt)
    );

    logic [1:0]         state_q, state_d;
    logic               href_prev_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               line_err_q, line_err_d;
    logic               frame_done_q, frame_done_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               found_href_q, found_href_d;

    logic               w_hrise, w_hfall, w_active, w_arm_go, w_frame_end;
    logic [COORD_W-1:0] w_x0, w_cw, w_x_sat, w_x_adv;
    logic [COORD_W:0]   w_x_inc;
    logic               w_hit_x, w_hit_y;

    assign w_hrise  = HREF && !href_prev_q;
    assign w_hfall  = !HREF && href_prev_q;
    assign w_active = (state_q == ST_ACTIVE);
    assign w_arm_go = (state_q == ST_ARMED) && !VSYNC;

    // Horizontal origin and width are pixel-pair aligned.
    assign w_x0    = CROP_X0 & ~COORD_W'(1);
    assign w_cw    = CROP_W & ~COORD_W'(1);
    assign w_x_inc = {1'b0, x_q} + (COORD_W+1)'(2);
    assign w_x_sat = w_x_inc[COORD_W] ? '1 : w_x_inc[COORD_W-1:0];
    assign w_x_adv = w_word_valid ? w_x_sat : x_q;

    assign w_hit_x = ({1'b0, x_q} >= {1'b0, w_x0}) &&
                     (w_x_inc <= ({1'b0, w_x0} + {1'b0, w_cw}));
    assign w_hit_y = ({1'b0, y_q} >= {1'b0, CROP_Y0}) &&
                     ({1'b0, y_q} < ({1'b0, CROP_Y0} + {1'b0, CROP_H}));

    assign w_frame_end = w_active && w_hfall && ((y_q + COORD_W'(1)) == FRAME_H);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (CAPON && VSYNC) state_d = ST_ARMED;
            ST_ARMED:  if (!VSYNC) state_d = ST_ACTIVE;
            ST_ACTIVE: if (w_frame_end || VSYNC) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        x_d = w_hrise ? '0 : w_x_adv;

        y_d = y_q;
        if (VSYNC) begin
            y_d = '0;
        end else if (w_active && w_hfall) begin
            y_d = y_q + COORD_W'(1);
        end

        // Line length is judged including the word that completes on this cycle.
        line_err_d = line_err_q;
        if (w_arm_go) begin
            line_err_d = 1'b0;
        end else if (w_active && w_hfall && ((w_x_adv != FRAME_W) || (w_byte_cnt != 2'd0))) begin
            line_err_d = 1'b1;
        end else if (w_active && VSYNC && !w_frame_end) begin
            line_err_d = 1'b1;
        end

        frame_done_d = w_frame_end;
        frame_cnt_d  = w_frame_end ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;

        found_href_d = found_href_q;
        if (VSYNC) begin
            found_href_d = 1'b0;
        end else if (HREF) begin
            found_href_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            state_q      <= ST_IDLE;
            href_prev_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            line_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            found_href_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            href_prev_q  <= HREF;
            x_q          <= x_d;
            y_q          <= y_d;
            line_err_q   <= line_err_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            found_href_q <= found_href_d;
        end
    end

    assign FIFOIN     = w_word;
    assign FIFOWR     = w_word_valid && w_active && w_hit_x && w_hit_y;
    assign FIFORST    = VSYNC;
    assign FOUND_HREF = found_href_q;
    assign FRAME_DONE = frame_done_q;
    assign LINE_ERR   = line_err_q;
    assign FRAME_CNT  = frame_cnt_q;

`ifdef CAM_CROP_DECODER_LUMA_SUM_EN
    logic [31:0] acc_q, acc_d, luma_q, luma_d;

    always_comb begin
        acc_d = acc_q;
        if (w_arm_go) begin
            acc_d = '0;
        end else if (FIFOWR) begin
            acc_d = acc_q + 32'(w_word[3*DATA_W-1 -: DATA_W]) + 32'(w_word[DATA_W-1:0]);
        end
        luma_d = frame_done_q ? acc_q : luma_q;
    end

    always_ff @(posedge PCLK) begin
        if (PRST) begin
            acc_q  <= '0;
            luma_q <= '0;
        end else begin
            acc_q  <= acc_d;
            luma_q <= luma_d;
        end
    end

    assign LUMA_SUM = luma_q;
`else
    assign LUMA_SUM = '0;
`endif

endmodule
`default_nettype wire

// File: doc/cam_crop_decoder.md
Name: cam_crop_decoder

Overview:
- Parametrised successor to the fixed VGA/SXGA camera byte decoder.
- Deserialises 8-bit 4:2:2 camera bytes into {U,Y0,V,Y1} pixel-pair words with a runtime-selectable byte order.
- Applies a runtime crop window of arbitrary origin and size, adds frame arming, line-length checking and a frame counter.
- Sits between the camera pins (PCLK domain) and the capture FIFO, ahead of colour conversion.

Parameters:
- DATA_W, 8, camera byte width; output word is 4*DATA_W.
- COORD_W, 12, width of all coordinate and size inputs and counters.
- FCNT_W, 16, width of FRAME_CNT.

Ports:
- PCLK in 1: camera pixel clock, sole clock.
- PRST in 1: synchronous active-high reset.
- CAPON in 1: capture enable, sampled at frame boundaries.
- HREF in 1: line-valid strobe.
- VSYNC in 1: frame sync, high between frames.
- CAMDATA in DATA_W: camera byte.
- ORDER in 2: byte order. 0 = UYVY, 1 = VYUY, 2 = YUYV, 3 = YVYU.
- FRAME_W, FRAME_H in COORD_W: expected line length in pixels and lines per frame.
- CROP_X0, CROP_Y0, CROP_W, CROP_H in COORD_W: crop origin and size. X0 and W LSBs are ignored (forced even).
- FIFOIN out 4*DATA_W: {U,Y0,V,Y1}, canonical order regardless of ORDER.
- FIFOWR out 1: write strobe for FIFOIN.
- FIFORST out 1: FIFO reset, equals VSYNC.
- FOUND_HREF out 1: HREF seen since last VSYNC.
- FRAME_DONE out 1: one-cycle pulse at the end of a captured frame.
- LINE_ERR out 1: sticky line-length or partial-group error.
- FRAME_CNT out FCNT_W: completed captured frames, wraps.
- LUMA_SUM out 32: see Optional Feature.

Behaviour:
- Reset values: all outputs and counters 0, FSM = IDLE. FIFORST follows VSYNC combinationally, even during reset.
- FSM transitions:
  - IDLE → ARMED when CAPON=1 and VSYNC=1.
  - ARMED → ACTIVE on the first cycle VSYNC=0.
  - ACTIVE → IDLE when y reaches FRAME_H, or when VSYNC rises early. An early VSYNC rise sets LINE_ERR and gives no FRAME_DONE.
  - Dropping CAPON mid-frame does not abort the frame; the frame completes first.
- Byte counter:
  - 2-bit, cleared whenever HREF=0, otherwise increments every cycle.
  - Byte k is routed to U/Y0/V/Y1 per the ORDER table; ORDER is sampled only while HREF=0.
- Write timing:
  - Word is valid the cycle after the 4th byte: counter==0 and prev_href=1. Latency from 4th byte to FIFOWR is 1 cycle.
  - FIFOWR = word valid AND state==ACTIVE AND window hit.
- Window hit, with (COORD_W+1)-bit compares:
  - CROP_X0 <= x and x+2 <= CROP_X0+CROP_W.
  - CROP_Y0 <= y < CROP_Y0+CROP_H.
  - CROP_W=0 or CROP_H=0 means no writes.
- Pixel position:
  - x counts pixels: cleared on HREF rising edge, +2 per word valid, saturates at all-ones.
  - y is cleared at VSYNC and increments on each HREF falling edge during ACTIVE.
- Line check on HREF falling edge:
  - LINE_ERR is set if x != FRAME_W, or if the counter != 0 (partial group).
  - A trailing partial group is discarded and never written.
  - LINE_ERR is cleared only by PRST or by the transition ARMED→ACTIVE.
- Frame end: when y reaches FRAME_H, FRAME_DONE pulses for one cycle and FRAME_CNT increments (wraps to 0).
- FOUND_HREF: set by HREF, cleared by VSYNC or PRST. VSYNC has priority.
- Reset mid-line: counters and FSM clear on the next edge; no FIFOWR until the next ARMED→ACTIVE.

Optional Feature:
- Macro CAM_CROP_DECODER_LUMA_SUM_EN.
- Enabled:
  - A 32-bit accumulator adds Y0+Y1 of every written word, cleared at ARMED→ACTIVE.
  - LUMA_SUM loads the accumulator on FRAME_DONE and holds until the next FRAME_DONE.
- Disabled: LUMA_SUM tied to 0 and no accumulator logic.

Decomposition:
- Package cam_crop_pkg:
  - ORDER encodings ORD_UYVY/ORD_VYUY/ORD_YUYV/ORD_YVYU.
  - FSM state encodings ST_IDLE/ST_ARMED/ST_ACTIVE.
- Sub-module cam_byte_sorter: byte counter, ORDER-based routing and the word-valid strobe. The top holds the FSM, counters, window and check logic.

Test Plan:
- VGA, UYVY, full window, CAPON=1, 640x480 frame → 320 FIFOWR per line, 153600 total. FIFOIN of the first word = {b0,b1,b2,b3}. FRAME_DONE once, FRAME_CNT=1.
- ORDER=2 (YUYV), bytes 10,20,30,40 → FIFOIN = {20,10,40,30}. FIFOWR exactly 1 cycle after byte 40.
- FRAME_W=1280, FRAME_H=1024, crop X0=128 Y0=128 W=1024 H=768 → 512 writes per line on lines 128..895 only. First write at x=128, none at x=1152.
- Line with 1283 bytes (one partial group) → LINE_ERR=1, last 3 bytes not written, LINE_ERR still 1 after the next frame's VSYNC until ARMED→ACTIVE.
- CAPON drops on line 100 → frame completes with FRAME_DONE. The next frame is not captured: no FIFOWR, FRAME_CNT unchanged.
- PRST asserted mid-line for 1 cycle → FIFOWR=0 and FRAME_CNT=0 from the next edge, FIFORST tracks VSYNC throughout.
